// File: rtl/uart_rx_fifo_pkg.sv
// Shared port map and decode helper for the uart rx fifo.
// Legacy data/status ports decode alongside the native ones.
package uart_rx_fifo_pkg;

  localparam int DEPTH_DEF = 16;

  localparam logic [7:0] UDATA     = 8'h80;
  localparam logic [7:0] UDATA_L0  = 8'h01;
  localparam logic [7:0] UDATA_L1  = 8'h07;
  localparam logic [7:0] USTAT     = 8'h83;
  localparam logic [7:0] USTATB_L0 = 8'h00;
  localparam logic [7:0] USTATB_L1 = 8'h06;
  localparam logic [7:0] URXCNT    = 8'h89;

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_DATA,
    SEL_STATA,
    SEL_STATB,
    SEL_CNT
  } port_sel_e;

  typedef struct packed {
    logic push;
    logic pop;
    logic flush;
    logic ovf_set;
    logic ovf_clr;
  } fifo_ctl_t;

  function automatic port_sel_e port_decode(
    input logic [7:0] addr
  );
    port_sel_e sel;
    sel = SEL_NONE;
    unique case (1'b1)
      (addr == UDATA),
      (addr == UDATA_L0),
      (addr == UDATA_L1):  sel = SEL_DATA;
      (addr == USTAT):     sel = SEL_STATA;
      (addr == USTATB_L0),
      (addr == USTATB_L1): sel = SEL_STATB;
      (addr == URXCNT):    sel = SEL_CNT;
      default:             sel = SEL_NONE;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/uart_rx_fifo_mem.sv
// Byte storage for the uart rx fifo.
// Synchronous write at tail, combinational read at head.
module rx_fifo_mem #(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive FIFO with CPU IO-port front end.
// Pops on the trailing edge of a data-port read strobe.
module uart_rx_fifo
  import uart_rx_fifo_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          RESET_n,
  input  logic [7:0]    rx_data,
  input  logic          rx_valid,
  input  logic [7:0]    cpu_addr,
  input  logic          cpu_io,
  input  logic          cpu_rd,
  input  logic          cpu_wr,
  input  logic          tx_busy,
  output logic [7:0]    io_dout,
  output logic          io_hit,
  output logic          rx_avail,
  output logic [AW:0]   rx_count
);

  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

  port_sel_e     sel;
  fifo_ctl_t     ctl;
  logic          hit;
  logic          rq;
  logic          sq;
  logic          rq_q;
  logic          sq_q;
  logic          empty;
  logic          full;
  logic          ovf_q;
  logic [AW-1:0] head_q;
  logic [AW-1:0] tail_q;
  logic [AW:0]   count_q;
  logic [AW:0]   count_d;
  logic [7:0]    head_byte;
  logic [7:0]    rd_mux;

  assign sel   = port_decode(cpu_addr);
  assign hit   = cpu_io & (sel != SEL_NONE);
  assign rq    = cpu_io & cpu_rd & (sel == SEL_DATA);
  assign sq    = cpu_io & cpu_rd & (sel == SEL_STATA);
  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_FULL);

  // A pop frees a slot in the same cycle, so a full FIFO still accepts.
  always_comb begin
    ctl         = '0;
    ctl.flush   = cpu_io & cpu_wr & (sel == SEL_CNT);
    ctl.pop     = rq_q & ~rq & ~empty & ~ctl.flush;
    ctl.push    = rx_valid & (~full | ctl.pop) & ~ctl.flush;
    ctl.ovf_set = rx_valid & full & ~ctl.pop;
    ctl.ovf_clr = sq_q & ~sq;
  end

  always_comb begin
    count_d = count_q;
    unique case (1'b1)
      (ctl.push & ~ctl.pop): count_d = count_q + CNT_ONE;
      (ctl.pop & ~ctl.push): count_d = count_q - CNT_ONE;
      default:               count_d = count_q;
    endcase
  end

  rx_fifo_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clock (clock),
    .we    (ctl.push),
    .waddr (tail_q),
    .wdata (rx_data),
    .raddr (head_q),
    .rdata (head_byte)
  );

  always_ff @(posedge clock or negedge RESET_n) begin
    if (!RESET_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      rq_q    <= 1'b0;
      sq_q    <= 1'b0;
    end else begin
      rq_q <= rq;
      sq_q <= sq;
      if (ctl.flush) begin
        head_q  <= '0;
        tail_q  <= '0;
        count_q <= '0;
        ovf_q   <= 1'b0;
      end else begin
        if (ctl.push) begin
          tail_q <= tail_q + PTR_ONE;
        end
        if (ctl.pop) begin
          head_q <= head_q + PTR_ONE;
        end
        count_q <= count_d;
        if (ctl.ovf_set) begin
          ovf_q <= 1'b1;
        end else if (ctl.ovf_clr) begin
          ovf_q <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    rd_mux = 8'h00;
    unique case (sel)
      SEL_DATA:  rd_mux = empty ? 8'h00 : head_byte;
      SEL_STATA: rd_mux = {ovf_q, 2'b00, ~empty, 3'b000, tx_busy};
      SEL_STATB: rd_mux = {tx_busy, 6'b0, empty};
      SEL_CNT:   rd_mux = 8'(count_q);
      default:   rd_mux = 8'h00;
    endcase
  end

  always_ff @(posedge clock or negedge RESET_n) begin
    if (!RESET_n) begin
      io_dout <= 8'h00;
      io_hit  <= 1'b0;
    end else begin
      io_hit <= hit;
      if (hit) begin
        io_dout <= rd_mux;
      end
    end
  end

  assign rx_avail = ~empty;
  assign rx_count = count_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: directed scenarios plus random traffic
// against a queue-based reference model.
module tb_uart_rx_fifo;

  localparam int DEPTH = 16;

  logic       clock;
  logic       RESET_n;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] cpu_addr;
  logic       cpu_io;
  logic       cpu_rd;
  logic       cpu_wr;
  logic       tx_busy;
  logic [7:0] io_dout;
  logic       io_hit;
  logic       rx_avail;
  logic [4:0] rx_count;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] q[$];
  logic       m_ovf;
  logic       m_rq_q;
  logic       m_sq_q;
  logic [7:0] m_dout;
  logic       m_hit;

  uart_rx_fifo #(.DEPTH(DEPTH)) dut (
    .clock    (clock),
    .RESET_n  (RESET_n),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .cpu_addr (cpu_addr),
    .cpu_io   (cpu_io),
    .cpu_rd   (cpu_rd),
    .cpu_wr   (cpu_wr),
    .tx_busy  (tx_busy),
    .io_dout  (io_dout),
    .io_hit   (io_hit),
    .rx_avail (rx_avail),
    .rx_count (rx_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic model_reset();
    q.delete();
    m_ovf  = 1'b0;
    m_rq_q = 1'b0;
    m_sq_q = 1'b0;
    m_dout = 8'h00;
    m_hit  = 1'b0;
  endtask

  task automatic idle();
    rx_valid = 1'b0;
    cpu_io   = 1'b0;
    cpu_rd   = 1'b0;
    cpu_wr   = 1'b0;
  endtask

  // Evaluate the model on the current inputs, then advance one clock.
  task automatic cycle();
    bit is_d, is_a, is_b, is_c, dec, rq, sq, pop, fl, full, set;
    is_d = (cpu_addr == 8'h80) || (cpu_addr == 8'h01) || (cpu_addr == 8'h07);
    is_a = (cpu_addr == 8'h83);
    is_b = (cpu_addr == 8'h00) || (cpu_addr == 8'h06);
    is_c = (cpu_addr == 8'h89);
    dec  = is_d || is_a || is_b || is_c;
    rq   = cpu_io && cpu_rd && is_d;
    sq   = cpu_io && cpu_rd && is_a;
    if (cpu_io && dec) begin
      if (is_d) m_dout = (q.size() != 0) ? q[0] : 8'h00;
      else if (is_a) m_dout = {m_ovf, 2'b00, q.size() != 0, 3'b000, tx_busy};
      else if (is_b) m_dout = {tx_busy, 6'b0, q.size() == 0};
      else m_dout = 8'(q.size());
    end
    m_hit = cpu_io && dec;
    fl    = cpu_io && cpu_wr && is_c;
    pop   = m_rq_q && !rq && (q.size() > 0);
    set   = 1'b0;
    if (fl) begin
      q.delete();
      m_ovf = 1'b0;
    end else begin
      full = (q.size() == DEPTH);
      if (pop) void'(q.pop_front());
      if (rx_valid) begin
        if (!full || pop) q.push_back(rx_data);
        else set = 1'b1;
      end
      if (m_sq_q && !sq) m_ovf = 1'b0;
      if (set) m_ovf = 1'b1;
    end
    m_rq_q = rq;
    m_sq_q = sq;
    @(posedge clock);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    cycle();
    rx_valid = 1'b0;
  endtask

  task automatic rd_start(input logic [7:0] a);
    cpu_io   = 1'b1;
    cpu_rd   = 1'b1;
    cpu_addr = a;
    cycle();
  endtask

  task automatic rd_end();
    cpu_io = 1'b0;
    cpu_rd = 1'b0;
    cycle();
  endtask

  task automatic flush();
    cpu_io   = 1'b1;
    cpu_wr   = 1'b1;
    cpu_addr = 8'h89;
    cycle();
    idle();
  endtask

  task automatic test_reset();
    idle();
    tx_busy  = 1'b0;
    rx_data  = 8'h00;
    cpu_addr = 8'h00;
    RESET_n  = 1'b0;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    n_vec++;
    if (io_dout !== 8'h00) begin
      n_err++;
      $display("FAIL reset_dout: got %h want 00", io_dout);
    end
    n_vec++;
    if (io_hit !== 1'b0) begin
      n_err++;
      $display("FAIL reset_hit: got %b want 0", io_hit);
    end
    n_vec++;
    if (rx_avail !== 1'b0 || rx_count !== 5'd0) begin
      n_err++;
      $display("FAIL reset_level: avail %b count %0d want 0 0", rx_avail, rx_count);
    end
    RESET_n = 1'b1;
    cycle();
  endtask

  task automatic test_basic();
    push_byte(8'h41);
    push_byte(8'h42);
    n_vec++;
    if (rx_count !== 5'd2 || rx_avail !== 1'b1) begin
      n_err++;
      $display("FAIL basic_count2: got %0d/%b want 2/1", rx_count, rx_avail);
    end
    rd_start(8'h80);
    cycle();
    n_vec++;
    if (io_dout !== 8'h41 || io_hit !== 1'b1) begin
      n_err++;
      $display("FAIL basic_rd1: dout %h hit %b want 41 1", io_dout, io_hit);
    end
    rd_end();
    n_vec++;
    if (rx_count !== 5'd1 || io_hit !== 1'b0) begin
      n_err++;
      $display("FAIL basic_count1: count %0d hit %b want 1 0", rx_count, io_hit);
    end
    rd_start(8'h80);
    cycle();
    n_vec++;
    if (io_dout !== 8'h42 || rx_avail !== 1'b1) begin
      n_err++;
      $display("FAIL basic_rd2: dout %h avail %b want 42 1", io_dout, rx_avail);
    end
    rd_end();
    n_vec++;
    if (rx_count !== 5'd0 || rx_avail !== 1'b0) begin
      n_err++;
      $display("FAIL basic_count0: count %0d avail %b want 0 0", rx_count, rx_avail);
    end
  endtask

  task automatic test_full_overflow();
    tx_busy = 1'b0;
    for (int i = 0; i < 17; i++) push_byte(8'(i));
    n_vec++;
    if (rx_count !== 5'd16) begin
      n_err++;
      $display("FAIL full_count: got %0d want 16", rx_count);
    end
    rd_start(8'h83);
    n_vec++;
    if (io_dout !== 8'h90) begin
      n_err++;
      $display("FAIL full_stata: got %h want 90", io_dout);
    end
    rd_end();
    for (int i = 0; i < 16; i++) begin
      rd_start(8'h80);
      n_vec++;
      if (io_dout !== 8'(i)) begin
        n_err++;
        $display("FAIL full_drain%0d: got %h want %h", i, io_dout, 8'(i));
      end
      rd_end();
    end
    rd_start(8'h07);
    n_vec++;
    if (io_dout !== 8'h00 || rx_count !== 5'd0) begin
      n_err++;
      $display("FAIL empty_read: dout %h count %0d want 00 0", io_dout, rx_count);
    end
    rd_end();
  endtask

  task automatic test_full_push_pop();
    for (int i = 0; i < 16; i++) push_byte(8'(8'hA0 + i));
    rd_start(8'h80);
    n_vec++;
    if (io_dout !== 8'hA0) begin
      n_err++;
      $display("FAIL pp_head: got %h want a0", io_dout);
    end
    cpu_io   = 1'b0;
    cpu_rd   = 1'b0;
    rx_valid = 1'b1;
    rx_data  = 8'h5A;
    cycle();
    rx_valid = 1'b0;
    n_vec++;
    if (rx_count !== 5'd16) begin
      n_err++;
      $display("FAIL pp_count: got %0d want 16", rx_count);
    end
    cpu_io   = 1'b1;
    cpu_addr = 8'h83;
    cycle();
    idle();
    n_vec++;
    if (io_dout !== 8'h10) begin
      n_err++;
      $display("FAIL pp_noovf: got %h want 10", io_dout);
    end
    for (int i = 0; i < 16; i++) begin
      logic [7:0] exp;
      exp = (i < 15) ? 8'(8'hA1 + i) : 8'h5A;
      rd_start(8'h01);
      n_vec++;
      if (io_dout !== exp) begin
        n_err++;
        $display("FAIL pp_drain%0d: got %h want %h", i, io_dout, exp);
      end
      rd_end();
    end
  endtask

  task automatic test_ovf_clear();
    tx_busy = 1'b0;
    for (int i = 0; i < 17; i++) push_byte(8'($urandom));
    rd_start(8'h83);
    n_vec++;
    if (io_dout[7] !== 1'b1) begin
      n_err++;
      $display("FAIL ovf_set: got %h want bit7 1", io_dout);
    end
    rd_end();
    rd_start(8'h83);
    n_vec++;
    if (io_dout !== 8'h10) begin
      n_err++;
      $display("FAIL ovf_clr: got %h want 10", io_dout);
    end
    cpu_io   = 1'b0;
    cpu_rd   = 1'b0;
    rx_valid = 1'b1;
    rx_data  = 8'hEE;
    cycle();
    rx_valid = 1'b0;
    rd_start(8'h83);
    n_vec++;
    if (io_dout !== 8'h90) begin
      n_err++;
      $display("FAIL ovf_set_wins: got %h want 90", io_dout);
    end
    rd_end();
    flush();
  endtask

  task automatic test_flush();
    for (int i = 0; i < 5; i++) push_byte(8'($urandom));
    n_vec++;
    if (rx_count !== 5'd5) begin
      n_err++;
      $display("FAIL flush_pre: got %0d want 5", rx_count);
    end
    cpu_io   = 1'b1;
    cpu_wr   = 1'b1;
    cpu_addr = 8'h89;
    rx_valid = 1'b1;
    rx_data  = 8'h99;
    cycle();
    idle();
    n_vec++;
    if (rx_count !== 5'd0 || rx_avail !== 1'b0) begin
      n_err++;
      $display("FAIL flush_count: count %0d avail %b want 0 0", rx_count, rx_avail);
    end
    tx_busy = 1'b1;
    rd_start(8'h00);
    n_vec++;
    if (io_dout !== 8'h81) begin
      n_err++;
      $display("FAIL flush_statb: got %h want 81", io_dout);
    end
    rd_end();
    rd_start(8'h01);
    n_vec++;
    if (io_dout !== 8'h00) begin
      n_err++;
      $display("FAIL flush_data: got %h want 00", io_dout);
    end
    rd_end();
    push_byte(8'h33);
    rd_start(8'h06);
    n_vec++;
    if (io_dout !== 8'h80) begin
      n_err++;
      $display("FAIL statb_avail: got %h want 80", io_dout);
    end
    rd_end();
    rd_start(8'h89);
    n_vec++;
    if (io_dout !== 8'h01) begin
      n_err++;
      $display("FAIL cnt_port: got %h want 01", io_dout);
    end
    rd_end();
    flush();
    tx_busy = 1'b0;
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) push_byte(8'(8'h60 + i));
    rd_start(8'h80);
    #3;
    RESET_n = 1'b0;
    #1;
    model_reset();
    n_vec++;
    if (io_dout !== 8'h00 || io_hit !== 1'b0) begin
      n_err++;
      $display("FAIL rstmid_io: dout %h hit %b want 00 0", io_dout, io_hit);
    end
    n_vec++;
    if (rx_count !== 5'd0 || rx_avail !== 1'b0) begin
      n_err++;
      $display("FAIL rstmid_lvl: count %0d avail %b want 0 0", rx_count, rx_avail);
    end
    idle();
    @(posedge clock);
    #2;
    RESET_n = 1'b1;
    @(posedge clock);
    #1;
    push_byte(8'h71);
    push_byte(8'h72);
    n_vec++;
    if (rx_count !== 5'd2) begin
      n_err++;
      $display("FAIL rstmid_post: got %0d want 2", rx_count);
    end
    rd_start(8'h80);
    rd_end();
    n_vec++;
    if (io_dout !== 8'h71 || rx_count !== 5'd1) begin
      n_err++;
      $display("FAIL rstmid_pop: dout %h count %0d want 71 1", io_dout, rx_count);
    end
    flush();
  endtask

  task automatic test_random();
    logic [7:0] addrs [8];
    addrs = '{8'h80, 8'h01, 8'h07, 8'h83, 8'h00, 8'h06, 8'h89, 8'h00};
    for (int c = 0; c < 3000; c++) begin
      addrs[7] = 8'($urandom);
      rx_valid = ($urandom_range(0, 99) < 45);
      rx_data  = 8'($urandom);
      cpu_io   = ($urandom_range(0, 99) < 60);
      cpu_rd   = ($urandom_range(0, 99) < 50);
      cpu_wr   = ($urandom_range(0, 99) < 3);
      cpu_addr = addrs[$urandom_range(0, 7)];
      tx_busy  = $urandom_range(0, 1) == 1;
      cycle();
      n_vec++;
      if (io_dout !== m_dout) begin
        n_err++;
        $display("FAIL rnd_dout c%0d: got %h want %h", c, io_dout, m_dout);
      end
      n_vec++;
      if (io_hit !== m_hit) begin
        n_err++;
        $display("FAIL rnd_hit c%0d: got %b want %b", c, io_hit, m_hit);
      end
      n_vec++;
      if (rx_count !== 5'(q.size()) || rx_avail !== (q.size() != 0)) begin
        n_err++;
        $display("FAIL rnd_level c%0d: count %0d avail %b want %0d", c, rx_count, rx_avail, q.size());
      end
    end
    idle();
    cycle();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full_overflow();
    test_full_push_pop();
    test_ovf_clear();
    test_flush();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
